// File: rtl/convert_pkg.sv
// convert_pkg
//   Shared constants and types for the 4-bit code converter.
//   - Mode encodings for the four conversions and the mode used when the
//     external mode select is disabled.
//   - Excess-3 offset and the valid code windows for BCD and XS3 inputs.
//   - conv_result_t: the 5-bit result word (4-bit code plus invalid flag)
//     that is passed from the combinational converter to the output register.
package convert_pkg;

    localparam logic [1:0] MODE_BIN2GRAY = 2'd0;
    localparam logic [1:0] MODE_GRAY2BIN = 2'd1;
    localparam logic [1:0] MODE_BCD2XS3  = 2'd2;
    localparam logic [1:0] MODE_XS32BCD  = 2'd3;

    // Conversion applied when mode_en is low.
    localparam logic [1:0] MODE_DEFAULT  = MODE_BIN2GRAY;

    localparam logic [3:0] XS3_OFFSET = 4'd3;
    localparam logic [3:0] BCD_MAX    = 4'd9;
    localparam logic [3:0] XS3_MIN    = 4'd3;
    localparam logic [3:0] XS3_MAX    = 4'd12;

    typedef struct packed {
        logic [3:0] y;
        logic       err;
    } conv_result_t;

endpackage

// File: rtl/convert_comb.sv
// convert_comb
//   Purely combinational nibble converter.
//   Ports:
//     x    [3:0] input  code word (bit 3 = MSB)
//     mode [1:0] input  effective conversion select (see convert_pkg)
//     y    [3:0] output converted code, 0000 when the input is invalid
//     err        output 1 when x is not a legal code for the selected mode
module convert_comb
    import convert_pkg::*;
(
    input  logic [3:0] x,
    input  logic [1:0] mode,
    output logic [3:0] y,
    output logic       err
);

    logic [3:0] gray_val;
    logic [3:0] bin_val;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_bits
            // Binary to Gray: each bit is the XOR of itself and its upper
            // neighbour; the MSB passes straight through.
            if (gi == 3) begin : g_msb
                assign gray_val[gi] = x[gi];
            end else begin : g_low
                assign gray_val[gi] = x[gi] ^ x[gi+1];
            end
            // Gray to binary: each bit is the XOR-reduction of all Gray
            // bits from the MSB down to this position.
            assign bin_val[gi] = ^x[3:gi];
        end
    endgenerate

    always_comb begin
        y   = 4'd0;
        err = 1'b0;
        case (mode)
            MODE_BIN2GRAY: y = gray_val;
            MODE_GRAY2BIN: y = bin_val;
            MODE_BCD2XS3: begin
                if (x <= BCD_MAX) begin
                    y = x + XS3_OFFSET;
                end else begin
                    err = 1'b1;
                end
            end
            MODE_XS32BCD: begin
                if ((x >= XS3_MIN) && (x <= XS3_MAX)) begin
                    y = x - XS3_OFFSET;
                end else begin
                    err = 1'b1;
                end
            end
            default: begin
                y   = 4'd0;
                err = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/code_convert.sv
// code_convert
//   4-bit code converter (binary/Gray/BCD/excess-3) with registered outputs.
//   Ports:
//     clk            system clock, rising edge
//     rst            asynchronous active-high reset, clears all outputs
//     a,b,c,d        input nibble, a = MSB, d = LSB
//     mode_en        1 = use mode, 0 = use MODE_DEFAULT (binary to Gray)
//     mode [1:0]     conversion select
//     e,f,g,h        registered result nibble, e = MSB, h = LSB
//     err            registered flag, 1 = input invalid for selected mode
//   The input and the mode are sampled on the same edge, so a simultaneous
//   change of both yields one consistent result one cycle later.
module code_convert
    import convert_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic       d,
    input  logic       mode_en,
    input  logic [1:0] mode,
    output logic       e,
    output logic       f,
    output logic       g,
    output logic       h,
    output logic       err
);

    logic [3:0]   x_in;
    logic [1:0]   mode_eff;
    conv_result_t result_next;
    conv_result_t result_reg;

    assign x_in     = {a, b, c, d};
    assign mode_eff = mode_en ? mode : MODE_DEFAULT;

    convert_comb u_convert_comb (
        .x    (x_in),
        .mode (mode_eff),
        .y    (result_next.y),
        .err  (result_next.err)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_reg <= '0;
        end else begin
            result_reg <= result_next;
        end
    end

    assign {e, f, g, h} = result_reg.y;
    assign err          = result_reg.err;

endmodule

// File: tb/tb_code_convert.sv
// tb_code_convert
//   Directed stimulus for code_convert. A behavioural model derived from the
//   code definitions (arithmetic and exhaustive Gray search) predicts every
//   registered output; one process compares it on each falling edge, and a
//   set of literal expectations pins both the model and the design.
module tb_code_convert;
    import convert_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0;
    logic       mode_en = 1'b0;
    logic [1:0] mode = 2'd0;
    logic       e, f, g, h, err;

    int errors = 0;
    int checks = 0;

    logic [3:0] exp_y   = 4'd0;
    logic       exp_err = 1'b0;
    logic       started = 1'b0;

    always #5 clk = ~clk;

    code_convert dut (
        .clk     (clk),
        .rst     (rst),
        .a       (a),
        .b       (b),
        .c       (c),
        .d       (d),
        .mode_en (mode_en),
        .mode    (mode),
        .e       (e),
        .f       (f),
        .g       (g),
        .h       (h),
        .err     (err)
    );

    // Reference conversion from the code definitions.
    function automatic logic [4:0] model(input logic [3:0] x, input logic [1:0] m);
        int xv;
        int r;
        logic bad;
        xv  = int'(x);
        r   = 0;
        bad = 1'b0;
        case (m)
            2'd0: r = xv ^ (xv >> 1);
            2'd1: begin
                // Find the binary value whose Gray code is x.
                for (int k = 0; k < 16; k++) begin
                    if ((k ^ (k >> 1)) == xv) r = k;
                end
            end
            2'd2: begin
                if (xv <= 9) r = (xv + 3) % 16;
                else bad = 1'b1;
            end
            default: begin
                if (xv >= 3 && xv <= 12) r = xv - 3;
                else bad = 1'b1;
            end
        endcase
        return {r[3:0], bad};
    endfunction

    // Model register: what the outputs must hold after each edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_y   <= 4'd0;
            exp_err <= 1'b0;
        end else begin
            {exp_y, exp_err} <= model({a, b, c, d}, mode_en ? mode : 2'd0);
        end
    end

    // Continuous compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            checks++;
            if ({e, f, g, h} !== exp_y || err !== exp_err) begin
                errors++;
                $display("FAIL model_cmp t=%0t got y=%b err=%b required y=%b err=%b",
                         $time, {e, f, g, h}, err, exp_y, exp_err);
            end
        end
    end

    task automatic check_lit(input string name, input logic [3:0] ey, input logic ee);
        checks++;
        if ({e, f, g, h} !== ey || err !== ee) begin
            errors++;
            $display("FAIL %s got y=%b err=%b required y=%b err=%b",
                     name, {e, f, g, h}, err, ey, ee);
        end else begin
            $display("ok   %s y=%b err=%b", name, {e, f, g, h}, err);
        end
    endtask

    // Drive one vector after a falling edge; the next rising edge captures it.
    task automatic apply(input logic [3:0] x, input logic men, input logic [1:0] m);
        @(negedge clk);
        {a, b, c, d} = x;
        mode_en      = men;
        mode         = m;
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string name, input logic [3:0] x, input logic men,
                        input logic [1:0] m, input logic [3:0] ey, input logic ee);
        apply(x, men, m);
        check_lit(name, ey, ee);
    endtask

    initial begin
        #1;
        rst = 1'b1;
        {a, b, c, d} = 4'b1111;
        #2;
        started = 1'b1;
        check_lit("reset_hold", 4'b0000, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_lit("reset_release", 4'b1000, 1'b0);
        // Asynchronous clear with no clock edge.
        #1 rst = 1'b1;
        #1 check_lit("reset_async", 4'b0000, 1'b0);
        rst = 1'b0;

        // Binary to Gray sweep on the default mode.
        for (int i = 0; i < 16; i++) apply(4'(i), 1'b0, 2'd3);
        step("b2g_0110", 4'b0110, 1'b0, 2'd2, 4'b0101, 1'b0);
        step("b2g_1011", 4'b1011, 1'b0, 2'd1, 4'b1110, 1'b0);
        step("b2g_1111", 4'b1111, 1'b0, 2'd0, 4'b1000, 1'b0);

        // Gray to binary.
        step("g2b_0101", 4'b0101, 1'b1, 2'd1, 4'b0110, 1'b0);
        step("g2b_1000", 4'b1000, 1'b1, 2'd1, 4'b1111, 1'b0);

        // Round trip: Gray code of i back through mode 1 must return i.
        for (int i = 0; i < 16; i++) begin
            logic [3:0] xi;
            logic [3:0] gi_code;
            xi      = 4'(i);
            gi_code = xi ^ (xi >> 1);
            apply(xi, 1'b1, 2'd0);
            step($sformatf("roundtrip_%0d", i), gi_code, 1'b1, 2'd1, xi, 1'b0);
        end

        // BCD to excess-3.
        step("bcd_0000", 4'b0000, 1'b1, 2'd2, 4'b0011, 1'b0);
        step("bcd_0111", 4'b0111, 1'b1, 2'd2, 4'b1010, 1'b0);
        step("bcd_1001", 4'b1001, 1'b1, 2'd2, 4'b1100, 1'b0);
        step("bcd_1010", 4'b1010, 1'b1, 2'd2, 4'b0000, 1'b1);
        step("bcd_1111", 4'b1111, 1'b1, 2'd2, 4'b0000, 1'b1);

        // Excess-3 to BCD.
        step("xs3_0011", 4'b0011, 1'b1, 2'd3, 4'b0000, 1'b0);
        step("xs3_1100", 4'b1100, 1'b1, 2'd3, 4'b1001, 1'b0);
        step("xs3_0010", 4'b0010, 1'b1, 2'd3, 4'b0000, 1'b1);
        step("xs3_1101", 4'b1101, 1'b1, 2'd3, 4'b0000, 1'b1);

        // Full sweep of every mode for the continuous compare.
        for (int m = 0; m < 4; m++)
            for (int i = 0; i < 16; i++) apply(4'(i), 1'b1, 2'(m));

        // Simultaneous input and mode change.
        step("simul_change", 4'b1101, 1'b1, 2'd0, 4'b1011, 1'b0);

        // Reset mid-stream.
        step("mid_before", 4'b0101, 1'b1, 2'd2, 4'b1000, 1'b0);
        #1 rst = 1'b1;
        #1 check_lit("mid_reset", 4'b0000, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_lit("mid_after", 4'b1000, 1'b0);

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
